// File: rtl/cnn_layer_accel_quad_job_ctrl_if.sv
// Quad job handshake bundle: scheduler descriptor port, quad job port,
// and config/pixel feeder trigger.
interface cnn_layer_accel_quad_job_ctrl_if;
  logic         desc_valid;
  logic         desc_ready;
  logic [127:0] desc_params;
  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;
  logic         fetch_start;
  logic         fetch_done;

  modport master (
    input  desc_valid, desc_params,
    input  job_accept, job_fetch_request,
    input  job_complete, fetch_done,
    output desc_ready, job_start,
    output job_parameters, job_fetch_ack,
    output job_fetch_complete, job_complete_ack,
    output fetch_start
  );

  modport slave (
    output desc_valid, desc_params,
    output job_accept, job_fetch_request,
    output job_complete, fetch_done,
    input  desc_ready, job_start,
    input  job_parameters, job_fetch_ack,
    input  job_fetch_complete, job_complete_ack,
    input  fetch_start
  );
endinterface

// File: rtl/cnn_layer_accel_quad_job_ctrl.sv
// One-job-at-a-time sequencer between the layer scheduler and a quad,
// with feeder triggering and a hung-job watchdog.
module cnn_layer_accel_quad_job_ctrl #(
  parameter int C_FETCH_CNT_W = 8,
  parameter int C_TIMEOUT_W   = 20,
  parameter logic [C_TIMEOUT_W-1:0] C_TIMEOUT_CYC =
    {C_TIMEOUT_W{1'b1}}
) (
  input  logic clk_if,
  input  logic rst,
  cnn_layer_accel_quad_job_ctrl_if.master bus,
  input  logic abort,
  output logic job_done,
  output logic [C_FETCH_CNT_W-1:0] job_fetch_cnt,
  output logic busy,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_FETCH, S_CMPL
  } state_t;

  state_t state, state_nxt;

  logic [127:0]           params_q;
  logic [C_TIMEOUT_W-1:0] wd_cnt;
  logic cmpl_pend;
  logic fetch_pls, fcmp_pls, done_pls;
  logic accept, ev, wd_exp;
  logic go_fetch, fetch_end, cmpl_end;

  assign accept = (state == S_IDLE) &&
                  bus.desc_valid && bus.desc_ready;

  // Level-held job_complete in CMPL must not keep the watchdog alive
  assign ev = bus.job_accept | bus.job_fetch_request |
              bus.fetch_done |
              (bus.job_complete && state != S_CMPL);

  assign wd_exp = (C_TIMEOUT_CYC != '0) &&
                  (state != S_IDLE) && !ev &&
                  (wd_cnt + C_TIMEOUT_W'(1) == C_TIMEOUT_CYC);

  always_ff @(posedge clk_if) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_fetch  = 1'b0;
    fetch_end = 1'b0;
    cmpl_end  = 1'b0;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: if (bus.job_accept) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.job_complete) begin
          state_nxt = S_CMPL;
        end else if (bus.job_fetch_request) begin
          state_nxt = S_FETCH;
          go_fetch  = 1'b1;
        end
      end
      S_FETCH: begin
        if (bus.fetch_done) begin
          fetch_end = 1'b1;
          state_nxt = (cmpl_pend || bus.job_complete) ?
                      S_CMPL : S_RUN;
        end
      end
      S_CMPL: begin
        if (!bus.job_complete) begin
          state_nxt = S_IDLE;
          cmpl_end  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && (abort || wd_exp)) begin
      state_nxt = S_IDLE;
      go_fetch  = 1'b0;
      fetch_end = 1'b0;
      cmpl_end  = 1'b0;
    end
  end

  always_comb begin
    bus.desc_ready         = (state == S_IDLE) && !done_pls;
    bus.job_start          = (state == S_START);
    bus.job_complete_ack   = (state == S_CMPL);
    bus.job_parameters     = params_q;
    bus.job_fetch_ack      = fetch_pls;
    bus.fetch_start        = fetch_pls;
    bus.job_fetch_complete = fcmp_pls;
    job_done               = done_pls;
    busy                   = (state != S_IDLE);
  end

  always_ff @(posedge clk_if) begin
    if (rst) begin
      params_q      <= '0;
      job_fetch_cnt <= '0;
      wd_cnt        <= '0;
      cmpl_pend     <= 1'b0;
      fetch_pls     <= 1'b0;
      fcmp_pls      <= 1'b0;
      done_pls      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      fetch_pls   <= go_fetch;
      fcmp_pls    <= fetch_end;
      done_pls    <= cmpl_end;
      timeout_err <= timeout_err | wd_exp;
      if (state_nxt != state || ev || state == S_IDLE)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + C_TIMEOUT_W'(1);
      if (accept) begin
        params_q      <= bus.desc_params;
        job_fetch_cnt <= '0;
      end else if (fetch_end && job_fetch_cnt != '1) begin
        job_fetch_cnt <= job_fetch_cnt + C_FETCH_CNT_W'(1);
      end
      if (state_nxt == S_IDLE)
        cmpl_pend <= 1'b0;
      else if (state == S_FETCH && bus.job_complete)
        cmpl_pend <= 1'b1;
    end
  end

endmodule
